// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Accepts one word per valid/ready handshake; o_tx is driven straight from a flop.
module uart_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 i_data_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx
);

    localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int TIMER_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W        = $clog2(DATA_BITS + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]   STOP_LAST  = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 bit_done;

    assign bit_done = (timer_q == TIMER_LAST);
    assign o_ready  = (state_q == S_IDLE);
    assign o_tx     = tx_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        timer_d = '0;
        cnt_d   = cnt_q;
        par_d   = par_q;

        // The bit timer restarts on every bit boundary, so each bit is exactly CLKS_PER_BIT cycles.
        if (state_q != S_IDLE && !bit_done) begin
            timer_d = timer_q + TIMER_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (i_data_valid) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    shift_d = i_data;
                    par_d   = (PARITY == 1) ? ~(^i_data) : ^i_data;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    if (cnt_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            shift_q <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: five instances with different frame formats, each line
// compared cycle by cycle against a frame model built from the frame rules.
module tb_uart_tx;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [4:0]      valid;
    logic [4:0][7:0] data;
    logic [4:0]      tx;
    logic [4:0]      ready;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_line[$];

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2 -- all at 10 clocks per bit. 4: default parameters.
    uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u0 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[0]), .i_data(data[0]), .o_ready(ready[0]), .o_tx(tx[0]));
    uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) u1 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[1]), .i_data(data[1]), .o_ready(ready[1]), .o_tx(tx[1]));
    uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) u2 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[2]), .i_data(data[2]), .o_ready(ready[2]), .o_tx(tx[2]));
    uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2), .PARITY(0)) u3 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[3]), .i_data(data[3][6:0]), .o_ready(ready[3]), .o_tx(tx[3]));
    uart_tx u4 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[4]), .i_data(data[4]), .o_ready(ready[4]), .o_tx(tx[4]));

    // Reference model: list the bit levels of one frame, then stretch each to cpb cycles.
    task automatic add_frame(input logic [7:0] w, input int nbits, input int par,
                             input int stops, input int cpb);
        int lv[$];
        int ones;
        ones = 0;
        lv.push_back(0);
        for (int i = 0; i < nbits; i++) begin
            lv.push_back(int'(w[i]));
            ones += int'(w[i]);
        end
        if (par == 2) lv.push_back(ones % 2);
        if (par == 1) lv.push_back(1 - (ones % 2));
        for (int s = 0; s < stops; s++) lv.push_back(1);
        foreach (lv[i]) begin
            for (int r = 0; r < cpb; r++) exp_line.push_back(lv[i]);
        end
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (tx[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_tx inst%0d o_tx=%b expected 1", k, tx[k]);
            end
            n_cmp++;
            if (ready[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_ready inst%0d o_ready=%b expected 1", k, ready[k]);
            end
        end
        valid[0] = 1'b0;
        n_rst    = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tx[0] !== 1'b1 || ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_valid_ignored o_tx=%b o_ready=%b expected 1 1", tx[0], ready[0]);
        end
    endtask

    // One frame on instance k, checked every cycle; optional one-cycle valid pulse at glitch_c.
    task automatic test_frame(input int k, input logic [7:0] w, input int nbits, input int par,
                              input int stops, input int cpb, input int glitch_c, input string name);
        int   n;
        int   lows;
        logic exp_t;
        exp_line.delete();
        add_frame(w, nbits, par, stops, cpb);
        n    = exp_line.size();
        lows = 0;
        @(negedge clk);
        n_cmp++;
        if (ready[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_before_send o_ready=%b expected 1", name, ready[k]);
        end
        valid[k] = 1'b1;
        data[k]  = w;
        for (int c = 0; c < n + 2 * cpb; c++) begin
            @(negedge clk);
            if (c == 0) valid[k] = 1'b0;
            if (c == glitch_c) begin
                valid[k] = 1'b1;
                data[k]  = 8'hFF;
            end
            if (glitch_c >= 0 && c == glitch_c + 1) valid[k] = 1'b0;
            exp_t = (c < n) ? (exp_line[c] != 0) : 1'b1;
            n_cmp++;
            if (tx[k] !== exp_t) begin
                n_bad++;
                $display("FAIL %s tx cycle %0d o_tx=%b expected %b", name, c, tx[k], exp_t);
            end
            n_cmp++;
            if (ready[k] !== (c >= n)) begin
                n_bad++;
                $display("FAIL %s ready cycle %0d o_ready=%b expected %b", name, c, ready[k], (c >= n));
            end
            if (ready[k] !== 1'b1) lows++;
        end
        n_cmp++;
        if (lows != (1 + nbits + ((par != 0) ? 1 : 0) + stops) * cpb) begin
            n_bad++;
            $display("FAIL %s frame_length got %0d cycles expected %0d", name, lows,
                     (1 + nbits + ((par != 0) ? 1 : 0) + stops) * cpb);
        end
    endtask

    task automatic test_parity();
        test_frame(1, 8'h07, 8, 2, 1, 10, -1, "even_07");
        test_frame(2, 8'h07, 8, 1, 1, 10, -1, "odd_07");
        test_frame(1, 8'h00, 8, 2, 1, 10, -1, "even_00");
    endtask

    task automatic test_back_to_back();
        int   n1;
        int   len;
        int   i;
        logic exp_t;
        logic exp_r;
        logic [7:0] w;
        int   cap[$];
        logic [7:0] got[$];
        exp_line.delete();
        add_frame(8'h55, 8, 0, 1, 10);
        n1 = exp_line.size();
        exp_line.push_back(1);
        add_frame(8'hAA, 8, 0, 1, 10);
        len = exp_line.size();
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'h55;
        for (int c = 0; c < len + 10; c++) begin
            @(negedge clk);
            if (c == 5) data[0] = 8'hAA;
            if (c == n1 + 1) valid[0] = 1'b0;
            exp_t = (c < len) ? (exp_line[c] != 0) : 1'b1;
            exp_r = (c == n1) || (c >= len);
            cap.push_back(int'(tx[0]));
            n_cmp++;
            if (tx[0] !== exp_t) begin
                n_bad++;
                $display("FAIL b2b tx cycle %0d o_tx=%b expected %b", c, tx[0], exp_t);
            end
            n_cmp++;
            if (ready[0] !== exp_r) begin
                n_bad++;
                $display("FAIL b2b ready cycle %0d o_ready=%b expected %b", c, ready[0], exp_r);
            end
        end
        // Receiver-style decode of the captured line: find a start bit, sample mid-bit.
        i = 0;
        while (i + 9 * 10 + 5 < cap.size()) begin
            if (cap[i] == 0) begin
                for (int b = 0; b < 8; b++) w[b] = (cap[i + 10 * (1 + b) + 5] != 0);
                got.push_back(w);
                i += 100;
            end else begin
                i++;
            end
        end
        n_cmp++;
        if (got.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_loopback_count got %0d words expected 2", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== 8'h55 || got[1] !== 8'hAA) begin
                n_bad++;
                $display("FAIL b2b_loopback_data got %h %h expected 55 aa", got[0], got[1]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic exp_t;
        exp_line.delete();
        add_frame(8'h0F, 8, 0, 1, 10);
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'h0F;
        for (int c = 0; c <= 43; c++) begin
            @(negedge clk);
            if (c == 0) valid[0] = 1'b0;
            exp_t = (exp_line[c] != 0);
            n_cmp++;
            if (tx[0] !== exp_t) begin
                n_bad++;
                $display("FAIL rst_mid tx cycle %0d o_tx=%b expected %b", c, tx[0], exp_t);
            end
        end
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        n_cmp++;
        if (tx[0] !== 1'b1 || ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_after_edge o_tx=%b o_ready=%b expected 1 1", tx[0], ready[0]);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (tx[0] !== 1'b1 || ready[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_mid_quiet cycle %0d o_tx=%b o_ready=%b expected 1 1", c, tx[0], ready[0]);
            end
        end
    endtask

    task automatic test_random();
        int nb[4] = '{8, 8, 8, 7};
        int pm[4] = '{0, 2, 1, 0};
        int sb[4] = '{1, 1, 1, 2};
        logic [7:0] w;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                w = 8'($urandom_range(0, (1 << nb[k]) - 1));
                test_frame(k, w, nb[k], pm[k], sb[k], 10, -1, $sformatf("rand_i%0d_%0d_%h", k, j, w));
            end
        end
    endtask

    initial begin
        valid = '0;
        data  = '0;
        n_rst = 1'b0;
        test_reset();
        test_frame(0, 8'hA5, 8, 0, 1, 10, -1, "8n1_a5");
        test_parity();
        test_frame(3, 8'h7F, 7, 0, 2, 10, -1, "7n2_7f");
        test_back_to_back();
        test_reset_midframe();
        test_frame(0, 8'h00, 8, 0, 1, 10, 35, "ignored_valid");
        test_random();
        // 50 MHz / 115200 baud rounds to 434 clocks per bit.
        test_frame(4, 8'($urandom_range(0, 255)), 8, 0, 1, 434, -1, "default_baud");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
